// File: rtl/muldiv_unit.sv
// Multi-cycle RV64 M-extension multiply/divide unit with valid/ready request and response ports.
// Multiplies wait out a fixed latency; divides use a restoring radix-2 loop on operand magnitudes.
module muldiv_unit #(
  parameter int XLEN    = 64,
  parameter int MUL_LAT = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt, cnt_lim;
  logic [XLEN-1:0] result_q, done_val;

  logic            accept;
  logic            dec_mul, dec_w, dec_sgn, dec_rem, dec_ill;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_neg, dvd_pre, dvd_res, spec_val;
  logic            a_neg, b_neg, zero_div, ovf;

  logic            w_q, rem_sel_q, neg_quo_q, neg_rem_q, byp_q;
  logic [XLEN-1:0] a_q, b_q, spec_q, quo_q, rem_q, dvs_q;
  logic [XLEN:0]   shifted, trial;
  logic [XLEN-1:0] rem_next, q_fix, r_fix, div_raw;
  logic            q_bit;
  logic [XLEN-1:0] prod_full;
  logic [31:0]     prod_w;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  assign accept = req_valid && req_ready;

  always_comb begin
    dec_mul = 1'b0;
    dec_w   = 1'b0;
    dec_sgn = 1'b0;
    dec_rem = 1'b0;
    dec_ill = 1'b0;
    case (op)
      4'd0: dec_mul = 1'b1;
      4'd1: dec_sgn = 1'b1;
      4'd2: ;
      4'd3: begin dec_sgn = 1'b1; dec_rem = 1'b1; end
      4'd4: dec_rem = 1'b1;
      4'd5: begin dec_mul = 1'b1; dec_w = 1'b1; end
      4'd6: begin dec_w = 1'b1; dec_sgn = 1'b1; end
      4'd7: dec_w = 1'b1;
      4'd8: begin dec_w = 1'b1; dec_sgn = 1'b1; dec_rem = 1'b1; end
      4'd9: begin dec_w = 1'b1; dec_rem = 1'b1; end
      default: dec_ill = 1'b1;
    endcase
    if (dec_w && XLEN != 64) dec_ill = 1'b1;
  end

  // Operands are widened to XLEN at the op's width so one divider serves both forms.
  always_comb begin
    a_ext   = src_a;
    b_ext   = src_b;
    min_neg = '0;
    min_neg[XLEN-1] = 1'b1;
    dvd_res = src_a;
    if (dec_w) begin
      a_ext   = dec_sgn ? sext32(src_a[31:0]) : XLEN'(src_a[31:0]);
      b_ext   = dec_sgn ? sext32(src_b[31:0]) : XLEN'(src_b[31:0]);
      min_neg = sext32(32'h8000_0000);
      dvd_res = sext32(src_a[31:0]);
    end
    a_neg    = dec_sgn & a_ext[XLEN-1];
    b_neg    = dec_sgn & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    dvd_pre  = dec_w ? (a_mag << (XLEN - 32)) : a_mag;
    zero_div = (b_ext == '0);
    ovf      = dec_sgn && (a_ext == min_neg) && (b_ext == '1);
    spec_val = '0;
    if (dec_ill)       spec_val = '0;
    else if (zero_div) spec_val = dec_rem ? dvd_res : '1;
    else if (ovf)      spec_val = dec_rem ? '0 : dvd_res;
  end

  always_comb begin
    shifted  = {rem_q, quo_q[XLEN-1]};
    trial    = shifted - {1'b0, dvs_q};
    q_bit    = ~trial[XLEN];
    rem_next = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    q_fix    = neg_quo_q ? -quo_q : quo_q;
    r_fix    = neg_rem_q ? -rem_q : rem_q;
    div_raw  = rem_sel_q ? r_fix : q_fix;
    prod_full = a_q * b_q;
    prod_w    = a_q[31:0] * b_q[31:0];
    case (state)
      MUL:     done_val = w_q ? sext32(prod_w) : prod_full;
      DIV:     done_val = byp_q ? spec_q : (w_q ? sext32(div_raw[31:0]) : div_raw);
      default: done_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      state <= next_state;
      if (flush || accept)
        cnt <= '0;
      else if (state == MUL || (state == DIV && cnt != cnt_lim))
        cnt <= cnt + CW'(1);
      if (next_state == DONE && state != DONE)
        result_q <= done_val;
    end
  end

  // Special cases and illegal ops pass through DIV for one cycle with no iterations,
  // so every op reaches DONE on a registered edge after the accept edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      w_q       <= dec_w;
      rem_sel_q <= dec_rem;
      neg_quo_q <= a_neg ^ b_neg;
      neg_rem_q <= a_neg;
      byp_q     <= dec_ill || zero_div || ovf;
      spec_q    <= spec_val;
      a_q       <= src_a;
      b_q       <= src_b;
      quo_q     <= dvd_pre;
      rem_q     <= '0;
      dvs_q     <= b_mag;
      cnt_lim   <= dec_w ? CW'(32) : CW'(XLEN);
    end else if (state == DIV && !byp_q && cnt != cnt_lim) begin
      rem_q <= rem_next;
      quo_q <= {quo_q[XLEN-2:0], q_bit};
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = (dec_mul && !dec_ill) ? MUL : DIV;
      MUL:  if (cnt == CW'(MUL_LAT - 1)) next_state = DONE;
      DIV:  if (byp_q || cnt == cnt_lim) next_state = DONE;
      DONE: if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  always_comb begin
    req_ready  = (state == IDLE) && !flush && !reset;
    resp_valid = (state == DONE);
    result     = result_q;
  end

endmodule
